// File: rtl/avalon_wait_mem.sv
// -----------------------------------------------------------------------------
// avalon_wait_mem
//
// Avalon-MM responder memory with a fixed waitrequest stall profile. Every
// transfer is held off for WAIT_CYCLES+1 cycles (acceptance cycle plus
// WAIT_CYCLES counted cycles) and completes in a single READY cycle in which
// waitrequest is low. A separate preload port writes whole words so a bench
// can load a program image while the bus is idle or busy.
//
// Parameters
//   ADDR_WIDTH   byte-address bits decoded; depth = 2^(ADDR_WIDTH-2) words,
//                upper address bits alias (must be < 32)
//   WAIT_CYCLES  counted stall cycles per transfer, legal range 1..15
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (FSM and registers only)
//   address      byte address, word index = address[ADDR_WIDTH-1:2]
//   read/write   bus requests; both high is treated as a write and flagged
//   writedata    write data
//   byteenable   lane enables, bit i covers writedata[8i+7:8i]
//   waitrequest  combinational stall
//   readdata     registered read data, valid in the READY cycle, held after
//   err          sticky protocol-error flag
//   inst_input   preload write enable
//   inst_addr    preload byte address
//   instruction  preload word (all lanes)
// -----------------------------------------------------------------------------
module avalon_wait_mem #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           address,
   input  logic                  read,
   input  logic                  write,
   input  logic [31:0]           writedata,
   input  logic [3:0]            byteenable,
   output logic                  waitrequest,
   output logic [31:0]           readdata,
   output logic                  err,
   input  logic                  inst_input,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic [31:0]           instruction
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_next;

   // Transfer context captured at acceptance; later bus changes are ignored.
   logic [ADDR_WIDTH-3:0] r_idx;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;
   logic                  r_is_write;

   logic [31:0]           r_mem [DEPTH];

   logic                  w_req;
   logic                  w_accept;
   logic                  w_abort;
   logic                  w_load_rd;
   logic                  w_commit;

   // Byte-offset and aliased upper address bits are intentionally not decoded.
   logic                  w_unused;
   assign w_unused = ^{address[31:ADDR_WIDTH], address[1:0], inst_addr[1:0]};

   assign w_req       = read | write;
   assign waitrequest = w_req & (r_state != S_READY);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path through the case leaves a signal unassigned (no latches).
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_abort      = 1'b0;
      w_load_rd    = 1'b0;
      w_commit     = 1'b0;

      case (r_state)
         S_IDLE: begin
            // A preload in progress holds off bus acceptance.
            if (w_req && !inst_input) begin
               w_accept     = 1'b1;
               w_cnt_next   = 4'(WAIT_CYCLES - 1);
               w_state_next = S_WAIT;
            end
         end

         S_WAIT: begin
            if (!w_req) begin
               // Master dropped its request mid-transfer: abandon it.
               w_abort      = 1'b1;
               w_cnt_next   = 4'd0;
               w_state_next = S_IDLE;
            end else if (r_cnt != 4'd0) begin
               w_cnt_next = r_cnt - 4'd1;
            end else begin
               w_load_rd    = ~r_is_write;
               w_state_next = S_READY;
            end
         end

         S_READY: begin
            w_commit     = r_is_write;
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated only with non-blocking assignments
      // so every register samples pre-edge values regardless of block order.
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // -------------------------------------------------------------------------
   // Transfer context, read data and error flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx      <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_is_write <= 1'b0;
         readdata   <= '0;
         err        <= 1'b0;
      end else begin
         if (w_accept) begin
            r_idx      <= address[ADDR_WIDTH-1:2];
            r_wdata    <= writedata;
            r_be       <= byteenable;
            r_is_write <= write;
         end
         if ((w_accept && read && write) || w_abort) begin
            err <= 1'b1;
         end
         if (w_load_rd) begin
            readdata <= r_mem[r_idx];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Memory array
   // -------------------------------------------------------------------------
   // NOTE: the array has no reset branch; contents survive reset and the
   // block maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (inst_input) begin
         r_mem[inst_addr[ADDR_WIDTH-1:2]] <= instruction;
      end
      // Placed after the preload so a bus write to the same word wins.
      // A reset in the READY cycle cancels the pending commit.
      if (w_commit && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
               r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_avalon_wait_mem.sv
// -----------------------------------------------------------------------------
// tb_avalon_wait_mem
//
// Directed bench for avalon_wait_mem with default parameters
// (ADDR_WIDTH=10, WAIT_CYCLES=2). Inputs change 1 ns after a rising edge;
// outputs are sampled on the falling edge or 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_avalon_wait_mem;

   localparam int AW = 10;

   logic          clk;
   logic          reset;
   logic [31:0]   address;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic [3:0]    byteenable;
   logic          waitrequest;
   logic [31:0]   readdata;
   logic          err;
   logic          inst_input;
   logic [AW-1:0] inst_addr;
   logic [31:0]   instruction;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] rdat;
   int          stalls;

   avalon_wait_mem #(
      .ADDR_WIDTH  (AW),
      .WAIT_CYCLES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .read        (read),
      .write       (write),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .waitrequest (waitrequest),
      .readdata    (readdata),
      .err         (err),
      .inst_input  (inst_input),
      .inst_addr   (inst_addr),
      .instruction (instruction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Master-side transfer: hold the request while waitrequest is high, take
   // readdata in the first cycle where it is low, then release the bus.
   // Called 1 ns after a rising edge; returns 1 ns after a rising edge.
   task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           output logic [31:0] data, output int n_stall);
      read       = rd;
      write      = wr;
      address    = a;
      writedata  = d;
      byteenable = be;
      data       = 'x;
      n_stall    = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!waitrequest) begin
            data = readdata;
            break;
         end
         n_stall++;
         next_cycle();
      end
      next_cycle();
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      inst_input  = 1'b1;
      inst_addr   = a;
      instruction = d;
      next_cycle();
      inst_input  = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      address     = '0;
      read        = 1'b0;
      write       = 1'b0;
      writedata   = '0;
      byteenable  = '0;
      inst_input  = 1'b0;
      inst_addr   = '0;
      instruction = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset_waitrequest", 32'(waitrequest), 32'd0);
      check("reset_readdata", readdata, 32'h0);
      check("reset_err", 32'(err), 32'd0);
      next_cycle();

      // Full-word write then read back, 3 stall cycles each
      bus_xfer(1'b0, 1'b1, 32'h04, 32'h2404FEDC, 4'hF, rdat, stalls);
      check("wr04_stalls", 32'(stalls), 32'd3);
      bus_xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, rdat, stalls);
      check("rd04_stalls", 32'(stalls), 32'd3);
      check("rd04_data", rdat, 32'h2404FEDC);
      check("rd04_err", 32'(err), 32'd0);

      // Partial byte-lane write and a zero-enable write
      preload(10'h20, 32'h11223344);
      bus_xfer(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rdat, stalls);
      bus_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rdat, stalls);
      check("be0101_data", rdat, 32'h11BB33DD);
      bus_xfer(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rdat, stalls);
      check("be0000_stalls", 32'(stalls), 32'd3);
      bus_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rdat, stalls);
      check("be0000_data", rdat, 32'h11BB33DD);

      // Aliasing: upper address bits beyond ADDR_WIDTH are ignored
      bus_xfer(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'hF, rdat, stalls);
      check("alias_data", rdat, 32'h2404FEDC);

      // Bus read held while a preload to the same word is in progress
      read        = 1'b1;
      address     = 32'h08;
      byteenable  = 4'hF;
      inst_input  = 1'b1;
      inst_addr   = 10'h08;
      instruction = 32'h00042100;
      @(negedge clk);
      check("preload_hold_wr0", 32'(waitrequest), 32'd1);
      next_cycle();
      @(negedge clk);
      check("preload_hold_wr1", 32'(waitrequest), 32'd1);
      next_cycle();
      inst_input = 1'b0;
      bus_xfer(1'b1, 1'b0, 32'h08, 32'h0, 4'hF, rdat, stalls);
      check("preload_rd_stalls", 32'(stalls), 32'd3);
      check("preload_rd_data", rdat, 32'h00042100);

      // read and write both high: treated as a write, err latches
      bus_xfer(1'b1, 1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, rdat, stalls);
      check("rw_stalls", 32'(stalls), 32'd3);
      check("rw_readdata_held", rdat, 32'h00042100);
      check("rw_err", 32'(err), 32'd1);
      bus_xfer(1'b1, 1'b0, 32'h0C, 32'h0, 4'hF, rdat, stalls);
      check("rw_mem", rdat, 32'hDEADBEEF);
      check("rw_err_sticky", 32'(err), 32'd1);

      // Reset clears err and readdata, memory survives
      pulse_reset();
      check("rst2_err", 32'(err), 32'd0);
      check("rst2_readdata", readdata, 32'h0);
      bus_xfer(1'b1, 1'b0, 32'h0C, 32'h0, 4'hF, rdat, stalls);
      check("rst2_mem_kept", rdat, 32'hDEADBEEF);

      // Read dropped in the first WAIT cycle
      read    = 1'b1;
      address = 32'h04;
      next_cycle();
      read = 1'b0;
      @(negedge clk);
      check("abort_waitrequest", 32'(waitrequest), 32'd0);
      next_cycle();
      check("abort_err", 32'(err), 32'd1);
      check("abort_readdata", readdata, 32'hDEADBEEF);
      bus_xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, rdat, stalls);
      check("abort_idle_stalls", 32'(stalls), 32'd3);
      check("abort_idle_data", rdat, 32'h2404FEDC);

      // Reset in the READY cycle of a write cancels the commit
      preload(10'h10, 32'hCAFEF00D);
      write      = 1'b1;
      address    = 32'h10;
      writedata  = 32'h12345678;
      byteenable = 4'hF;
      stalls     = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!waitrequest) break;
         stalls++;
         next_cycle();
      end
      check("rstready_stalls", 32'(stalls), 32'd3);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      write = 1'b0;
      @(negedge clk);
      check("rstready_readdata", readdata, 32'h0);
      check("rstready_err", 32'(err), 32'd0);
      next_cycle();
      bus_xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rdat, stalls);
      check("rstready_mem_kept", rdat, 32'hCAFEF00D);

      // Bus write beats a same-cycle preload to the same word
      write      = 1'b1;
      address    = 32'h14;
      writedata  = 32'h55AA55AA;
      byteenable = 4'hF;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!waitrequest) break;
         next_cycle();
      end
      inst_input  = 1'b1;
      inst_addr   = 10'h14;
      instruction = 32'h0BADF00D;
      next_cycle();
      inst_input = 1'b0;
      write      = 1'b0;
      bus_xfer(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, rdat, stalls);
      check("collide_bus_wins", rdat, 32'h55AA55AA);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
